shift_rotate_pipe: RTL

Parametrised, pipelined shift/rotate unit. It is the next generation of the single-cycle shifter inside the execute-stage ALU. It adds arithmetic-right and rotate-both-ways modes, configurable width and pipeline depth, valid/ready backpressure, a destination-tag passthrough and flush. It sits beside the ALU in execute and feeds the execute/memory pipeline register (dest value plus dest index).

---
 rtl/uRISC_pkg.sv | 17 +
 rtl/shift_level.sv | 29 ++
 rtl/shift_rotate_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uRISC_pkg.sv
// Shared execute-stage definitions: shift/rotate operation encoding.
package uRISC_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_op_t;

    // Codes above SH_ROR are reserved.
    function automatic logic shift_op_legal(input logic [2:0] op);
        return (op <= 3'(SH_ROR));
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: moves data by DIST bit positions when en is set.
module shift_level
    import uRISC_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] out_data
);

    always_comb begin
        out_data = in_data;
        if (en) begin
            // Illegal encodings fall through to default and pass data unchanged.
            case (shift_op_t'(op))
                SH_SLL:  out_data = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SH_SRL:  out_data = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
                SH_SRA:  out_data = {{DIST{in_data[WIDTH-1]}}, in_data[WIDTH-1:DIST]};
                SH_ROL:  out_data = {in_data[WIDTH-DIST-1:0], in_data[WIDTH-1:WIDTH-DIST]};
                SH_ROR:  out_data = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
                default: out_data = in_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit with valid/ready handshake, tag passthrough and flush.
// Barrel levels are spread over NUM_STAGES register stages; stage 0 levels sit before register 0.
module shift_rotate_pipe
    import uRISC_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SHAMT_W    = $clog2(WIDTH),
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned TAG_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal,
    output logic               busy
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] ill_q;
    logic [WIDTH-1:0]      data_q [NUM_STAGES];
    logic [SHAMT_W-1:0]    amt_q  [NUM_STAGES];
    logic [2:0]            op_q   [NUM_STAGES];
    logic [TAG_W-1:0]      tag_q  [NUM_STAGES];

    // Per-stage view of what feeds each register, and the shifted result it would load.
    logic [NUM_STAGES-1:0] src_valid;
    logic [NUM_STAGES-1:0] src_ill;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [WIDTH-1:0]      src_data  [NUM_STAGES];
    logic [SHAMT_W-1:0]    src_amt   [NUM_STAGES];
    logic [2:0]            src_op    [NUM_STAGES];
    logic [TAG_W-1:0]      src_tag   [NUM_STAGES];
    logic [WIDTH-1:0]      stage_out [NUM_STAGES];

    assign in_ready = rst & ~flush & stage_ready[0];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_valid[k] = in_valid & in_ready;
            assign src_ill[k]   = ~shift_op_legal(in_op);
            assign src_data[k]  = in_data;
            assign src_amt[k]   = in_amt;
            assign src_op[k]    = in_op;
            assign src_tag[k]   = in_tag;
        end else begin : g_body
            assign src_valid[k] = valid_q[k-1];
            assign src_ill[k]   = ill_q[k-1];
            assign src_data[k]  = data_q[k-1];
            assign src_amt[k]   = amt_q[k-1];
            assign src_op[k]    = op_q[k-1];
            assign src_tag[k]   = tag_q[k-1];
        end

        // A stage can take a new beat if it is empty or its occupant moves on this cycle.
        if (k == LAST) begin : g_tail
            assign stage_ready[k] = ~valid_q[k] | out_ready;
        end else begin : g_mid
            assign stage_ready[k] = ~valid_q[k] | stage_ready[k+1];
        end

        logic [WIDTH-1:0] chain [SHAMT_W+1];
        assign chain[0] = src_data[k];

        for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
            if ((i * NUM_STAGES) / SHAMT_W == k) begin : g_on
                shift_level #(
                    .WIDTH (WIDTH),
                    .DIST  (1 << i)
                ) u_level (
                    .in_data  (chain[i]),
                    .op       (src_op[k]),
                    .en       (src_amt[k][i]),
                    .out_data (chain[i+1])
                );
            end else begin : g_off
                assign chain[i+1] = chain[i];
            end
        end

        assign stage_out[k] = chain[SHAMT_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            ill_q   <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                op_q[k]   <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (stage_ready[k]) begin
                    valid_q[k] <= src_valid[k];
                end
                // Payload only moves with a real beat so a stalled output stays stable.
                if (stage_ready[k] && src_valid[k]) begin
                    data_q[k] <= stage_out[k];
                    amt_q[k]  <= src_amt[k];
                    op_q[k]   <= src_op[k];
                    ill_q[k]  <= src_ill[k];
                    tag_q[k]  <= src_tag[k];
                end
            end
        end
    end

    assign out_valid   = valid_q[LAST];
    assign out_data    = data_q[LAST];
    assign out_tag     = tag_q[LAST];
    assign out_illegal = ill_q[LAST];
    assign busy        = |valid_q;

endmodule
